tile_loader: RTL and testbench
==============================

Name: tile_loader

Overview:
Producer side of the convolution pixel-matrix interface. Assembles a raster stream of pixels into a 4x4 tile, presents it on buffer_pixels with a one-cycle load_enable strobe, then steps select through the four 3x3 window positions (00, 01, 10, 11), advancing on each conv_done from the convolution datapath. Sits between the input pixel FIFO and the pixel matrix / MAC stage.

Parameters:
PIXEL_W, 4, bits per pixel; must match the pixel-matrix element width.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
flush  input  1  synchronous abort: drop partial tile and window sequence
pixel_valid  input  1  pixel_data valid this cycle
pixel_data  input  PIXEL_W  incoming pixel, row-major tile order
pixel_ready  output  1  loader accepts pixel_data this cycle
conv_done  input  1  single-cycle pulse: convolution for the current select finished
buffer_pixels  output  [3:0][3:0][PIXEL_W-1:0]  tile; [r][c] = row r, column c
load_enable  output  1  one-cycle strobe; pixel matrix latches buffer_pixels on this edge
select  output  2  window position presented to the pixel matrix
win_valid  output  1  select is valid and awaiting conv_done
tile_done  output  1  one-cycle pulse after the 4th window completes
fill_count  output  5  pixels held in the current tile, 0..16

Behaviour:
- Reset (n_rst=0, asynchronous): state FILL; fill_count=0; buffer_pixels all 0; load_enable=0; select=00; win_valid=0; tile_done=0; pixel_ready=1 once reset releases.
- Clock and reset: clk, with n_rst as the asynchronous active-low reset.
- States: FILL, LOAD, WIN.
- FILL: pixel_ready=1 while fill_count<16. Transfer when pixel_valid&&pixel_ready. Pixel k (k=fill_count) is written to buffer_pixels[k>>2][k&3], then fill_count increments. When fill_count reaches 16, go to LOAD on the next cycle. pixel_ready=0 at fill_count=16.
- LOAD: exactly one cycle with load_enable=1; buffer_pixels is stable during it. Next state WIN. select=00, win_cnt=0.
- WIN: win_valid=1 and select=win_cnt. First valid select appears the cycle after load_enable.
  - On conv_done with win_cnt<3: win_cnt increments; new select is visible the next cycle.
  - On conv_done with win_cnt==3: tile_done=1 for the next cycle, select returns to 00, win_valid=0, and fill_count clears to 0. Buffer contents persist until overwritten.
  - Next state is FILL, or LOAD when the optional feature holds a full tile.
- conv_done outside WIN is ignored. Only one window advance happens per cycle.
- flush (highest priority after reset): in the following cycle the block is in state FILL with fill_count=0, win_valid=0, select=00 and no tile_done. buffer_pixels is not cleared. A pixel offered in the flush cycle is dropped.
- load_enable, tile_done and win_valid are registered and glitch-free. select changes only on clock edges.
- Latency: 16 accepted pixels, then load_enable one cycle after the 16th transfer. Minimum tile period is 16 + 1 + 4 cycles without the optional feature.

Optional Feature:
Macro EARLY_FILL_EN.
- Defined: filling of the next tile continues during WIN. This is safe because the pixel matrix already holds its latched copy.
  - fill_count restarts at 0 in the LOAD cycle, and pixels are accepted from the cycle after LOAD.
  - If the tile reaches 16 before the 4th conv_done, pixel_ready=0 and the tile is held.
  - On the 4th conv_done the state goes directly to LOAD next cycle, with tile_done and load_enable asserted in the same cycle.
- Undefined: pixel_ready=0 throughout LOAD and WIN. FILL resumes only after tile_done.

Test Plan:
1. Reset, then stream pixels 0..15 (value = index mod 16) with pixel_valid=1 continuously -> buffer_pixels[r][c]=4r+c; load_enable is high exactly one cycle, 1 cycle after the 16th transfer; select=00 and win_valid=1 the next cycle.
2. Full tile loaded, then conv_done pulses with 2-cycle gaps -> select 00, 01, 10, 11 in sequence; tile_done for 1 cycle after the 4th pulse; select=00; pixel_ready=1 (EARLY_FILL_EN undefined).
3. pixel_valid toggling 1,0,1,0 -> only valid cycles counted; fill_count reaches 16 after 32 cycles; no pixel is duplicated or skipped.
4. flush asserted at fill_count=9, and again in WIN with select=10 -> fill_count=0, win_valid=0, select=00, no tile_done; the next 16 pixels form a clean tile.
5. n_rst pulsed low mid-WIN (select=01) -> all outputs return to reset values immediately, asynchronously.
6. EARLY_FILL_EN defined: stream 32 pixels continuously while conv_done arrives every 8 cycles -> second tile is held at fill_count=16; load_enable coincides with the first tile's tile_done cycle; buffer_pixels[0][0]=second tile's first pixel.

Source files
------------

// File: rtl/tile_loader_if.sv
// Pixel-stream and window-handshake bundle between the tile loader and its
// neighbours. The master modport is the loader side; slave is the environment
// side (input pixel FIFO, pixel matrix and convolution datapath).
interface tile_loader_if #(
  parameter int PIXEL_W = 4
);
  logic                             pixel_valid;
  logic [PIXEL_W-1:0]               pixel_data;
  logic                             pixel_ready;
  logic                             conv_done;
  logic [3:0][3:0][PIXEL_W-1:0]     buffer_pixels;
  logic                             load_enable;
  logic [1:0]                       select;
  logic                             win_valid;
  logic                             tile_done;
  logic [4:0]                       fill_count;

  modport master (
    input  pixel_valid, pixel_data, conv_done,
    output pixel_ready, buffer_pixels, load_enable, select, win_valid,
           tile_done, fill_count
  );

  modport slave (
    output pixel_valid, pixel_data, conv_done,
    input  pixel_ready, buffer_pixels, load_enable, select, win_valid,
           tile_done, fill_count
  );
endinterface

// File: rtl/tile_loader.sv
// Tile loader: gathers 16 raster pixels into a 4x4 tile, strobes load_enable
// for one cycle, then walks select through the four 3x3 window positions,
// advancing on each conv_done. flush drops any partial tile / window walk.
// Optional macro EARLY_FILL_EN: keep filling the next tile during the window
// walk and chain straight into the next LOAD when that tile is complete.
module tile_loader #(
  parameter int PIXEL_W = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          flush,
  tile_loader_if.master bus
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [4:0]                     fill_q, fill_d;
  logic [3:0][3:0][PIXEL_W-1:0]   buf_q, buf_d;
  logic [1:0]                     win_cnt_q, win_cnt_d;
  logic                           load_q, load_d;
  logic                           winv_q, winv_d;
  logic                           tdone_q, tdone_d;

  logic                           fill_open_s;
  logic                           ready_s;
  logic                           xfer_s;

  // Decide whether the tile buffer may take a pixel this cycle.
  always_comb begin
    fill_open_s = 1'b0;
`ifdef EARLY_FILL_EN
    // The pixel matrix holds its own copy once LOAD has passed, so the
    // buffer may be refilled while windows are still being processed.
    if ((state_q == ST_FILL) || (state_q == ST_WIN)) begin
      fill_open_s = 1'b1;
    end else begin
      fill_open_s = 1'b0;
    end
`else
    if (state_q == ST_FILL) begin
      fill_open_s = 1'b1;
    end else begin
      fill_open_s = 1'b0;
    end
`endif
    // A pixel offered together with flush is dropped, so refuse it.
    ready_s = fill_open_s && (fill_q < 5'd16) && !flush;
    xfer_s  = ready_s && bus.pixel_valid;
  end

  // Next-state, buffer write and window stepping.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    win_cnt_d = win_cnt_q;
    tdone_d   = 1'b0;

    if (xfer_s) begin
      buf_d[fill_q[3:2]][fill_q[1:0]] = bus.pixel_data;
      fill_d = fill_q + 5'd1;
    end else begin
      fill_d = fill_q;
    end

    if (flush) begin
      state_d   = ST_FILL;
      fill_d    = 5'd0;
      win_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_d == 5'd16) begin
            state_d   = ST_LOAD;
            win_cnt_d = 2'd0;
`ifdef EARLY_FILL_EN
            fill_d    = 5'd0;
`endif
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_LOAD: begin
          state_d = ST_WIN;
        end
        ST_WIN: begin
          if (bus.conv_done) begin
            if (win_cnt_q == 2'd3) begin
              tdone_d   = 1'b1;
              win_cnt_d = 2'd0;
`ifdef EARLY_FILL_EN
              // A next tile completed during the walk goes straight to LOAD.
              if (fill_d == 5'd16) begin
                state_d = ST_LOAD;
                fill_d  = 5'd0;
              end else begin
                state_d = ST_FILL;
              end
`else
              state_d = ST_FILL;
              fill_d  = 5'd0;
`endif
            end else begin
              win_cnt_d = win_cnt_q + 2'd1;
            end
          end else begin
            win_cnt_d = win_cnt_q;
          end
        end
        default: begin
          state_d   = ST_FILL;
          fill_d    = 5'd0;
          win_cnt_d = 2'd0;
        end
      endcase
    end

    load_d = (state_d == ST_LOAD);
    winv_d = (state_d == ST_WIN);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_FILL;
      fill_q    <= 5'd0;
      buf_q     <= '0;
      win_cnt_q <= 2'd0;
      load_q    <= 1'b0;
      winv_q    <= 1'b0;
      tdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      win_cnt_q <= win_cnt_d;
      load_q    <= load_d;
      winv_q    <= winv_d;
      tdone_q   <= tdone_d;
    end
  end

  assign bus.pixel_ready   = ready_s;
  assign bus.buffer_pixels = buf_q;
  assign bus.load_enable   = load_q;
  assign bus.select        = win_cnt_q;
  assign bus.win_valid     = winv_q;
  assign bus.tile_done     = tdone_q;
  assign bus.fill_count    = fill_q;

endmodule

// File: tb/tb_tile_loader.sv
// Directed self-checking bench for tile_loader (both EARLY_FILL_EN builds).
module tb_tile_loader;

  localparam int PIXEL_W = 4;

  logic clk;
  logic n_rst;
  logic flush;
  int   n_checks;
  int   n_errors;

  tile_loader_if #(.PIXEL_W(PIXEL_W)) bus ();

  tile_loader #(.PIXEL_W(PIXEL_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_buf;
    int          sent;
    int          wc;
    logic        xfer;
    logic        done;
    logic        hold_seen;

    n_checks = 0;
    n_errors = 0;
    n_rst = 1'b0;
    flush = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_data  = 4'd0;
    bus.conv_done   = 1'b0;
    done = 1'b0;
    hold_seen = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fill", bus.fill_count, 64'd0);
    check_eq("rst_load", bus.load_enable, 64'd0);
    check_eq("rst_sel", bus.select, 64'd0);
    check_eq("rst_winv", bus.win_valid, 64'd0);
    check_eq("rst_tdone", bus.tile_done, 64'd0);
    check_eq("rst_buf", bus.buffer_pixels, 64'd0);
    n_rst = 1'b1;
    #1;
    check_eq("rst_ready", bus.pixel_ready, 64'd1);

    // Test 1: continuous stream 0..15
    for (int k = 0; k < 16; k++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 4'(k);
      tick();
      if (k < 15) begin
        check_eq("t1_fill", bus.fill_count, 64'(k + 1));
        check_eq("t1_noload", bus.load_enable, 64'd0);
      end
    end
    bus.pixel_valid = 1'b0;
    check_eq("t1_load", bus.load_enable, 64'd1);
    check_eq("t1_ready_lo", bus.pixel_ready, 64'd0);
    check_eq("t1_buf", bus.buffer_pixels, 64'hFEDCBA9876543210);
    check_eq("t1_winv_lo", bus.win_valid, 64'd0);
`ifdef EARLY_FILL_EN
    check_eq("t1_fill_load", bus.fill_count, 64'd0);
`else
    check_eq("t1_fill_load", bus.fill_count, 64'd16);
`endif
    tick();
    check_eq("t1_load_off", bus.load_enable, 64'd0);
    check_eq("t1_winv", bus.win_valid, 64'd1);
    check_eq("t1_sel", bus.select, 64'd0);

    // Test 2: four windows, conv_done with 2-cycle gaps
    for (int w = 0; w < 4; w++) begin
      check_eq("t2_sel", bus.select, 64'(w));
      check_eq("t2_winv", bus.win_valid, 64'd1);
`ifdef EARLY_FILL_EN
      check_eq("t2_ready", bus.pixel_ready, 64'd1);
`else
      check_eq("t2_ready", bus.pixel_ready, 64'd0);
`endif
      tick();
      tick();
      check_eq("t2_sel_hold", bus.select, 64'(w));
      bus.conv_done = 1'b1;
      tick();
      bus.conv_done = 1'b0;
    end
    check_eq("t2_tdone", bus.tile_done, 64'd1);
    check_eq("t2_sel0", bus.select, 64'd0);
    check_eq("t2_winv0", bus.win_valid, 64'd0);
    check_eq("t2_ready1", bus.pixel_ready, 64'd1);
    check_eq("t2_fill0", bus.fill_count, 64'd0);
    check_eq("t2_noload", bus.load_enable, 64'd0);
    tick();
    check_eq("t2_tdone_off", bus.tile_done, 64'd0);

    // conv_done outside WIN is ignored
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    check_eq("idle_cd_sel", bus.select, 64'd0);
    check_eq("idle_cd_winv", bus.win_valid, 64'd0);
    check_eq("idle_cd_tdone", bus.tile_done, 64'd0);

    // Test 3: pixel_valid toggling, stale data on idle cycles
    for (int c = 0; c < 32; c++) begin
      bus.pixel_valid = ((c % 2) == 0);
      bus.pixel_data  = ((c % 2) == 0) ? 4'(15 - c / 2) : 4'h5;
      tick();
      if (c == 15) check_eq("t3_fill8", bus.fill_count, 64'd8);
      if (c == 29) check_eq("t3_noload", bus.load_enable, 64'd0);
      if (c == 30) check_eq("t3_load", bus.load_enable, 64'd1);
    end
    bus.pixel_valid = 1'b0;
    check_eq("t3_winv", bus.win_valid, 64'd1);
    check_eq("t3_buf", bus.buffer_pixels, 64'h0123456789ABCDEF);
    // Back-to-back conv_done: one advance per cycle
    bus.conv_done = 1'b1;
    for (int w = 0; w < 4; w++) begin
      tick();
      if (w < 3) check_eq("t3_sel", bus.select, 64'(w + 1));
      else       check_eq("t3_tdone", bus.tile_done, 64'd1);
    end
    bus.conv_done = 1'b0;
    check_eq("t3_sel0", bus.select, 64'd0);

    // Test 4: flush at fill_count=9
    for (int k = 0; k < 9; k++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 4'(k);
      tick();
    end
    check_eq("t4_fill9", bus.fill_count, 64'd9);
    flush = 1'b1;
    bus.pixel_data = 4'h9;
    tick();
    flush = 1'b0;
    bus.pixel_valid = 1'b0;
    check_eq("t4_fl_fill", bus.fill_count, 64'd0);
    check_eq("t4_fl_winv", bus.win_valid, 64'd0);
    check_eq("t4_fl_sel", bus.select, 64'd0);
    check_eq("t4_fl_tdone", bus.tile_done, 64'd0);
    check_eq("t4_fl_load", bus.load_enable, 64'd0);
    exp_buf = '0;
    for (int k = 0; k < 16; k++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 4'((k + 7) % 16);
      exp_buf[k*4 +: 4] = 4'((k + 7) % 16);
      tick();
    end
    bus.pixel_valid = 1'b0;
    check_eq("t4_load", bus.load_enable, 64'd1);
    check_eq("t4_buf", bus.buffer_pixels, exp_buf);
    tick();
    bus.conv_done = 1'b1;
    tick();
    tick();
    bus.conv_done = 1'b0;
    check_eq("t4_sel2", bus.select, 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("t4_wfl_winv", bus.win_valid, 64'd0);
    check_eq("t4_wfl_sel", bus.select, 64'd0);
    check_eq("t4_wfl_tdone", bus.tile_done, 64'd0);
    check_eq("t4_wfl_fill", bus.fill_count, 64'd0);
    check_eq("t4_wfl_load", bus.load_enable, 64'd0);
    tick();
    check_eq("t4_wfl_tdone2", bus.tile_done, 64'd0);
    check_eq("t4_wfl_winv2", bus.win_valid, 64'd0);
    exp_buf = '0;
    for (int k = 0; k < 16; k++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = 4'((3 * k + 1) % 16);
      exp_buf[k*4 +: 4] = 4'((3 * k + 1) % 16);
      tick();
    end
    bus.pixel_valid = 1'b0;
    check_eq("t4_load2", bus.load_enable, 64'd1);
    check_eq("t4_buf2", bus.buffer_pixels, exp_buf);
    tick();
    check_eq("t4_winv2", bus.win_valid, 64'd1);

    // Test 5: asynchronous reset mid-WIN at select=01
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    check_eq("t5_sel1", bus.select, 64'd1);
    #3;
    n_rst = 1'b0;
    #1;
    check_eq("t5_winv", bus.win_valid, 64'd0);
    check_eq("t5_sel", bus.select, 64'd0);
    check_eq("t5_fill", bus.fill_count, 64'd0);
    check_eq("t5_load", bus.load_enable, 64'd0);
    check_eq("t5_tdone", bus.tile_done, 64'd0);
    check_eq("t5_buf", bus.buffer_pixels, 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

`ifdef EARLY_FILL_EN
    // Test 6: 32-pixel stream, conv_done every 8 WIN cycles
    sent = 0;
    wc = 0;
    for (int t = 0; t < 200; t++) begin
      if (!done) begin
        bus.pixel_valid = (sent < 32);
        bus.pixel_data  = (sent < 16) ? 4'(sent) : 4'(31 - sent);
        bus.conv_done   = bus.win_valid && (wc == 7);
        if (bus.win_valid) wc = (wc == 7) ? 0 : wc + 1;
        #1;
        xfer = bus.pixel_valid && bus.pixel_ready;
        @(posedge clk);
        #1;
        if (xfer) sent++;
        if (bus.win_valid && (bus.fill_count == 5'd16) && !hold_seen) begin
          hold_seen = 1'b1;
          check_eq("t6_hold_ready", bus.pixel_ready, 64'd0);
        end
        if (bus.tile_done) begin
          done = 1'b1;
          check_eq("t6_load_with_tdone", bus.load_enable, 64'd1);
          check_eq("t6_fill0", bus.fill_count, 64'd0);
          check_eq("t6_winv0", bus.win_valid, 64'd0);
          check_eq("t6_buf", bus.buffer_pixels, 64'h0123456789ABCDEF);
          check_eq("t6_buf00", bus.buffer_pixels[0][0], 64'd15);
          check_eq("t6_sent", 64'(sent), 64'd32);
        end
      end
    end
    bus.conv_done = 1'b0;
    bus.pixel_valid = 1'b0;
    check_eq("t6_done", done, 64'd1);
    check_eq("t6_hold_seen", hold_seen, 64'd1);
    tick();
    check_eq("t6_winv_next", bus.win_valid, 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
